mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported 64-bit memory between the pipeline's instruction fetch (IF) and data memory (MEM) stages.
//  Sequences each access as a req/ready transaction to memory and returns a one-cycle valid to the winning requester.
//  Drives per-side stall outputs that the pipeline uses to freeze PC and the IF/ID and EX/MEM registers.
//  Data side has priority; a streak limit stops instruction fetch from starving.
// PARAMETERS
//  MAX_DM_STREAK  4   consecutive DM grants allowed while if_req pending (1..15)
// PORTS
//  clk         in   1   clock, all state updates on rising edge
//  reset       in   1   synchronous, active-high
//  if_req      in   1   fetch request, level; held with if_addr stable until if_valid
//  if_addr     in   64  fetch byte address (bits [1:0] ignored)
//  if_rdata    out  32  instruction word
//  if_valid    out  1   1-cycle pulse, if_rdata valid
//  dm_req      in   1   data request, level; held with dm_* stable until dm_valid
//  dm_we       in   1   1 = store, 0 = load
//  dm_addr     in   64  data byte address (doubleword access)
//  dm_wdata    in   64  store data
//  dm_rdata    out  64  load data
//  dm_valid    out  1   1-cycle pulse, load data / store completion
//  mem_req     out  1   memory request, held until mem_ready sampled high
//  mem_we      out  1   memory write enable
//  mem_addr    out  64  memory address
//  mem_wdata   out  64  memory write data
//  mem_rdata   in   64  memory read data, valid when mem_ready=1
//  mem_ready   in   1   memory completion, sampled only while mem_req=1
//  stall_if    out  1   if_req & ~if_valid (combinational)
//  stall_mem   out  1   dm_req & ~dm_valid (combinational)
// BEHAVIOUR
//  Reset: state=IDLE, streak=0; mem_req, mem_we, if_valid, dm_valid = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
//  FSM states:
//  - IDLE: arbitrate.
//    dm_req & ~(if_req & streak==MAX_DM_STREAK) -> BUSY_DM.
//    else if_req -> BUSY_IF.
//    else stay in IDLE.
//  - Grant: registers mem_addr, mem_we, mem_wdata; mem_req=1 from the next cycle.
//    IF grant: mem_we=0, mem_addr={if_addr[63:3],3'b000}.
//  - BUSY_IF / BUSY_DM: hold mem_* stable.
//    On mem_ready=1: mem_req=0, capture data, pulse the side's valid next cycle, return to IDLE.
//  - Issue turnaround: an issue cycle always follows IDLE, so back-to-back transactions are separated by 1 IDLE cycle.
//  - Minimum latency: req in cycle n -> mem_req n+1 -> mem_ready n+1 -> valid n+2.
//  Data extraction: if_rdata = if_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0], registered with if_valid.
//  Stores: dm_valid still pulses; dm_rdata is not updated on stores.
//  Streak counter:
//  - DM grant while if_req=1 increments (saturates at MAX_DM_STREAK).
//  - IF grant clears it.
//  - DM grant with if_req=0 clears it.
//  Simultaneous if_req & dm_req with streak<MAX: DM wins; IF waits, stall_if=1.
//  mem_ready while IDLE or while mem_req=0: ignored.
//  Requester drops req mid-transaction: the transaction still completes; the valid pulse is still generated.
//  Reset mid-transaction: abort to IDLE next edge; no valid pulse; the outstanding memory response is ignored.
//  Req still high after valid: treated as a new transaction, re-arbitrated in IDLE.
// CONFIGURATION
//  ARB_PERF_CNT_EN defined: adds outputs perf_if_wait[31:0] and perf_dm_wait[31:0].
//  - Each counts cycles with stall_if / stall_mem = 1.
//  - Saturate at 32'hFFFFFFFF; cleared by reset.
//  ARB_PERF_CNT_EN undefined: these ports and counters do not exist; all other behaviour identical.
// TESTING
//  1. Lone fetch: if_req=1, if_addr=64'h1004, memory returns 64'hAAAA_BBBB_1111_2222 with 0 wait.
//     -> mem_addr=64'h1000, mem_we=0; if_rdata=32'hAAAABBBB, if_valid 2 cycles after req.
//  2. Load and store: dm_req=1, dm_we=1, dm_addr=64'h2008, dm_wdata=64'h55.
//     -> mem_we=1, mem_wdata=64'h55, dm_valid pulse.
//     Then a load of 64'h2008 -> dm_rdata=64'h55.
//  3. Contention: if_req and dm_req both held, MAX_DM_STREAK=4, dm_req re-raised after each dm_valid.
//     -> grant order DM,DM,DM,DM,IF,DM...; stall_if=1 throughout until its valid.
//  4. Wait states: mem_ready delayed 3 cycles.
//     -> mem_req/mem_addr stable for 4 cycles; exactly one valid pulse.
//  5. Reset during BUSY_DM with mem_ready arriving 1 cycle after reset.
//     -> no dm_valid; state IDLE; mem_req=0; next if_req served normally.
//  6. With ARB_PERF_CNT_EN: scenario 3 for 20 cycles -> perf_if_wait equals the counted stall_if cycles exactly.
//     Reset -> counters read 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported 64-bit memory between instruction fetch and data access.
// Optional wait-cycle counters are enabled by defining ARB_PERF_CNT_EN.
module mem_port_arbiter #(
    parameter int MAX_DM_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [63:0] dm_addr,
    input  logic [63:0] dm_wdata,
    output logic [63:0] dm_rdata,
    output logic        dm_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ready,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0] perf_if_wait,
    output logic [31:0] perf_dm_wait,
`endif
    output logic        stall_if,
    output logic        stall_mem
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    state_t      state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
    logic        if_sel_q, if_sel_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        dm_valid_q, dm_valid_d;
    logic [63:0] dm_rdata_q, dm_rdata_d;

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_sel_d    = if_sel_q;
        if_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_valid_d  = 1'b0;
        dm_rdata_d  = dm_rdata_q;
        case (state_q)
            IDLE: begin
                // Data side wins unless fetch has already been passed over STREAK_MAX times
                if (dm_req && !(if_req && streak_q == STREAK_MAX)) begin
                    state_d     = BUSY_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    if (!if_req)
                        streak_d = 4'd0;
                    else if (streak_q != STREAK_MAX)
                        streak_d = streak_q + 4'd1;
                end else if (if_req) begin
                    state_d    = BUSY_IF;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {if_addr[63:3], 3'b000};
                    if_sel_d   = if_addr[2];
                    streak_d   = 4'd0;
                end
            end
            BUSY_IF: begin
                if (mem_ready) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    if_valid_d = 1'b1;
                    if_rdata_d = if_sel_q ? mem_rdata[63:32] : mem_rdata[31:0];
                end
            end
            BUSY_DM: begin
                if (mem_ready) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    dm_valid_d = 1'b1;
                    if (!mem_we_q)
                        dm_rdata_d = mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            streak_q    <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 64'd0;
            mem_wdata_q <= 64'd0;
            if_sel_q    <= 1'b0;
            if_valid_q  <= 1'b0;
            if_rdata_q  <= 32'd0;
            dm_valid_q  <= 1'b0;
            dm_rdata_q  <= 64'd0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_sel_q    <= if_sel_d;
            if_valid_q  <= if_valid_d;
            if_rdata_q  <= if_rdata_d;
            dm_valid_q  <= dm_valid_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_valid  = if_valid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_valid  = dm_valid_q;
    assign dm_rdata  = dm_rdata_q;
    assign stall_if  = if_req & ~if_valid_q;
    assign stall_mem = dm_req & ~dm_valid_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_q, perf_if_d;
    logic [31:0] perf_dm_q, perf_dm_d;

    always_comb begin
        perf_if_d = perf_if_q;
        perf_dm_d = perf_dm_q;
        if (stall_if && perf_if_q != 32'hFFFF_FFFF)
            perf_if_d = perf_if_q + 32'd1;
        if (stall_mem && perf_dm_q != 32'hFFFF_FFFF)
            perf_dm_d = perf_dm_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_if_q <= 32'd0;
            perf_dm_q <= 32'd0;
        end else begin
            perf_if_q <= perf_if_d;
            perf_dm_q <= perf_dm_d;
        end
    end

    assign perf_if_wait = perf_if_q;
    assign perf_dm_wait = perf_dm_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a wait-state memory responder.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [63:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req;
    logic        dm_we;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic [63:0] dm_rdata;
    logic        dm_valid;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready;
    logic        stall_if;
    logic        stall_mem;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_wait;
    logic [31:0] perf_dm_wait;
    int          ref_if_wait;
`endif

    int checks = 0;
    int errors = 0;

    logic [63:0] mem [logic [63:0]];
    int          wait_cfg = 0;
    int          wcnt = 0;
    bit          manual = 1'b0;
    logic        req_prev = 1'b0;
    logic [63:0] grants [$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_DM_STREAK(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
`ifdef ARB_PERF_CNT_EN
        .perf_if_wait(perf_if_wait), .perf_dm_wait(perf_dm_wait),
`endif
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    // Memory responder: answers after wait_cfg wait cycles, logs each new request address
    always @(negedge clk) begin
        if (mem_req && !req_prev)
            grants.push_back(mem_addr);
        req_prev = mem_req;
        if (!manual) begin
            if (mem_req) begin
                if (wcnt >= wait_cfg) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 64'd0;
                end else begin
                    mem_ready = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ready = 1'b0;
                wcnt = 0;
            end
        end
    end

    always @(posedge clk) begin
        if (mem_req && mem_ready && mem_we)
            mem[mem_addr] = mem_wdata;
`ifdef ARB_PERF_CNT_EN
        if (reset)
            ref_if_wait = 0;
        else if (stall_if)
            ref_if_wait++;
`endif
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_if(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (if_valid) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    task automatic wait_dm(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (dm_valid) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    initial begin
        int  pulses;
        int  vidx;
        bit  stable;
        bit  stall_bad;
        bit  got_if;

        mem[64'h1000] = 64'hAAAA_BBBB_1111_2222;
        mem[64'h3000] = 64'h0000_000C_0000_000D;
        mem[64'h4000] = 64'h0000_0000_0000_0044;
        reset = 1'b1; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_valids", {62'd0, if_valid, dm_valid}, 64'd0);
        chk("rst_stall", {62'd0, stall_if, stall_mem}, 64'd0);
`ifdef ARB_PERF_CNT_EN
        chk("rst_perf", {perf_if_wait, perf_dm_wait}, 64'd0);
`endif

        // Lone fetch with zero wait
        if_req = 1'b1; if_addr = 64'h1004;
        tick();
        chk("if_mem_req", 64'(mem_req), 64'd1);
        chk("if_mem_addr", mem_addr, 64'h1000);
        chk("if_mem_we", 64'(mem_we), 64'd0);
        chk("if_stall_wait", 64'(stall_if), 64'd1);
        chk("if_valid_early", 64'(if_valid), 64'd0);
        tick();
        chk("if_valid_n2", 64'(if_valid), 64'd1);
        chk("if_rdata", 64'(if_rdata), 64'hAAAA_BBBB);
        chk("if_stall_done", 64'(stall_if), 64'd0);
        if_req = 1'b0;
        tick();
        chk("if_valid_pulse", 64'(if_valid), 64'd0);
        chk("if_idle_req", 64'(mem_req), 64'd0);

        // Store then load of the same doubleword
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h2008; dm_wdata = 64'h55;
        tick();
        chk("st_mem_we", 64'(mem_we), 64'd1);
        chk("st_mem_wdata", mem_wdata, 64'h55);
        chk("st_mem_addr", mem_addr, 64'h2008);
        chk("st_stall", 64'(stall_mem), 64'd1);
        tick();
        chk("st_valid", 64'(dm_valid), 64'd1);
        chk("st_rdata_kept", dm_rdata, 64'd0);
        dm_req = 1'b0;
        tick();
        chk("st_valid_pulse", 64'(dm_valid), 64'd0);
        dm_we = 1'b0; dm_req = 1'b1;
        wait_dm("ld_timeout");
        chk("ld_rdata", dm_rdata, 64'h55);
        dm_req = 1'b0;
        tick();

        // Contention: data side wins four times, then fetch gets through
        grants.delete();
        if_req = 1'b1; if_addr = 64'h3000;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h4000;
        stall_bad = 1'b0; got_if = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!got_if) begin
                if (if_valid) begin
                    got_if = 1'b1;
                    chk("ct_if_rdata", 64'(if_rdata), 64'h0000_000D);
                end else if (!stall_if) begin
                    stall_bad = 1'b1;
                end
            end
            if (got_if && grants.size() >= 6) break;
        end
        chk("ct_if_served", 64'(got_if), 64'd1);
        chk("ct_stall_if_held", 64'(stall_bad), 64'd0);
        chk("ct_grant_count", 64'(grants.size() >= 6), 64'd1);
        if (grants.size() >= 6) begin
            for (int g = 0; g < 6; g++)
                chk($sformatf("ct_grant%0d", g), grants[g], (g == 4) ? 64'h3000 : 64'h4000);
        end
        if_req = 1'b0; dm_req = 1'b0;
        repeat (4) tick();
        chk("ct_drained", 64'(mem_req), 64'd0);

        // Three wait states on a load
        wait_cfg = 3;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h2008;
        pulses = 0; vidx = -1; stable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i < 4 && !(mem_req && mem_addr == 64'h2008))
                stable = 1'b0;
            if (dm_valid) begin
                pulses++;
                if (vidx < 0) vidx = i;
                dm_req = 1'b0;
            end
        end
        chk("ws_stable", 64'(stable), 64'd1);
        chk("ws_pulses", 64'(pulses), 64'd1);
        chk("ws_valid_cycle", 64'(vidx), 64'd4);
        chk("ws_rdata", dm_rdata, 64'h55);
        wait_cfg = 0;
        dm_req = 1'b0;
        tick();

        // Reset while the data access is outstanding; late response must be ignored
        manual = 1'b1; mem_ready = 1'b0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h2008;
        tick();
        chk("rs_busy", 64'(mem_req), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0; dm_req = 1'b0;
        mem_ready = 1'b1; mem_rdata = 64'hDEAD;
        chk("rs_mem_req", 64'(mem_req), 64'd0);
        chk("rs_rdata_clr", dm_rdata, 64'd0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (dm_valid || if_valid || mem_req) pulses++;
        end
        chk("rs_no_valid", 64'(pulses), 64'd0);
        mem_ready = 1'b0; manual = 1'b0;
        if_req = 1'b1; if_addr = 64'h1000;
        wait_if("rs_if_timeout");
        chk("rs_if_rdata", 64'(if_rdata), 64'h1111_2222);
        if_req = 1'b0;
        tick();

`ifdef ARB_PERF_CNT_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("pf_rst", {perf_if_wait, perf_dm_wait}, 64'd0);
        if_req = 1'b1; if_addr = 64'h3000;
        dm_req = 1'b1; dm_addr = 64'h4000;
        repeat (20) tick();
        if_req = 1'b0; dm_req = 1'b0;
        repeat (4) tick();
        chk("pf_if_wait", 64'(perf_if_wait), 64'(ref_if_wait));
        chk("pf_nonzero", 64'(perf_if_wait != 0), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
